// File: rtl/rx_peak_report_buffer.sv
// rx_peak_report_buffer: queues peak reports (sample, sequence ID, timestamp)
// captured on a trigger strobe and hands each one to the ARM side as two
// 32-bit words over a valid/ack handshake.
// Optional feature macro: RX_PEAK_DROP_CNT_EN adds a saturating drop counter
// (o_drop_cnt). While overflow is flagged, its low bits are tagged into word1[31:29].
module rx_peak_report_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          crx_clk,
    input  logic          rrx_rst,
    input  logic          erx_en,
    input  logic [40:0]   i_sample_arm,
    input  logic [3:0]    i_received_seq,
    input  logic [15:0]   i_time_arm,
    input  logic          i_trigger_arm,
    input  logic          i_rd_ack,
    output logic [31:0]   o_rd_data,
    output logic          o_rd_valid,
    output logic          o_rd_word,
    output logic [AW:0]   o_level,
    output logic          o_irq,
`ifdef RX_PEAK_DROP_CNT_EN
    output logic [7:0]    o_drop_cnt,
`endif
    output logic          o_overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD0 = 2'd1,
        WORD1 = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

    // Entry layout: {seq[3:0], time[15:0], sample[40:0]} = 61 bits
    logic [60:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_ptr_inc;
    logic [AW:0]    level_next;
    state_t         state;
    state_t         next_state;
    logic           pop;
    logic           write_accept;
    logic           drop;
    logic           remaining_nz;
    logic [60:0]    new_entry;
    logic [60:0]    head_entry;
    logic [31:0]    next_word0;
    logic [31:0]    head_word1;
    logic [2:0]     word1_tag;

`ifdef RX_PEAK_DROP_CNT_EN
    logic [7:0]     drop_cnt;
`endif

    // Write/pop decisions; a pop in the same cycle frees a slot for a full-FIFO write
    always_comb begin
        new_entry    = {i_received_seq, i_time_arm, i_sample_arm};
        head_entry   = mem[rd_ptr];
        rd_ptr_inc   = rd_ptr + AW'(1);
        pop          = erx_en && (state == WORD1) && i_rd_ack;
        write_accept = erx_en && i_trigger_arm && ((o_level != FULL_LEVEL) || pop);
        drop         = erx_en && i_trigger_arm && (o_level == FULL_LEVEL) && !pop;
        remaining_nz = (o_level != ONE_LEVEL) || write_accept;
        // When the popped entry was the last one, the next head is the entry being written now
        if ((o_level == ONE_LEVEL) && write_accept) begin
            next_word0 = i_sample_arm[31:0];
        end else begin
            next_word0 = mem[rd_ptr_inc][31:0];
        end
        level_next = o_level;
        if (write_accept && !pop) begin
            level_next = o_level + ONE_LEVEL;
        end else if (!write_accept && pop) begin
            level_next = o_level - ONE_LEVEL;
        end
`ifdef RX_PEAK_DROP_CNT_EN
        word1_tag = o_overflow ? drop_cnt[2:0] : 3'b000;
`else
        word1_tag = 3'b000;
`endif
        head_word1 = {word1_tag, head_entry[60:32]};
    end

    // Report storage; contents need no reset because pointers define validity
    always_ff @(posedge crx_clk) begin
        if (write_accept && !rrx_rst) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, fill level, interrupt and sticky overflow flag
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_level    <= '0;
            o_irq      <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (write_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            o_level <= level_next;
            o_irq   <= (level_next != '0);
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef RX_PEAK_DROP_CNT_EN
    // Saturating count of dropped reports
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`endif

    // Read FSM state register
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Read FSM next-state: word0 is only accepted once it is actually presented
    always_comb begin
        next_state = state;
        if (erx_en) begin
            case (state)
                IDLE: begin
                    if (o_level != '0) begin
                        next_state = WORD0;
                    end
                end
                WORD0: begin
                    if (o_rd_valid && i_rd_ack) begin
                        next_state = WORD1;
                    end
                end
                WORD1: begin
                    if (i_rd_ack) begin
                        next_state = remaining_nz ? WORD0 : IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Registered read port: first load of word0 after IDLE costs one cycle, then words follow acks directly
    always_ff @(posedge crx_clk) begin
        if (rrx_rst) begin
            o_rd_data  <= 32'd0;
            o_rd_valid <= 1'b0;
            o_rd_word  <= 1'b0;
        end else if (erx_en) begin
            case (state)
                IDLE: begin
                    o_rd_data  <= 32'd0;
                    o_rd_valid <= 1'b0;
                    o_rd_word  <= 1'b0;
                end
                WORD0: begin
                    if (!o_rd_valid) begin
                        o_rd_data  <= head_entry[31:0];
                        o_rd_valid <= 1'b1;
                        o_rd_word  <= 1'b0;
                    end else if (i_rd_ack) begin
                        o_rd_data  <= head_word1;
                        o_rd_word  <= 1'b1;
                    end
                end
                WORD1: begin
                    if (i_rd_ack) begin
                        if (remaining_nz) begin
                            o_rd_data  <= next_word0;
                            o_rd_valid <= 1'b1;
                            o_rd_word  <= 1'b0;
                        end else begin
                            o_rd_data  <= 32'd0;
                            o_rd_valid <= 1'b0;
                            o_rd_word  <= 1'b0;
                        end
                    end
                end
                default: begin
                    o_rd_data  <= 32'd0;
                    o_rd_valid <= 1'b0;
                    o_rd_word  <= 1'b0;
                end
            endcase
        end
    end

endmodule
